// File: rtl/fft8_pkg.sv
// Shared constants, state enum and schedule tables for the 8-point FFT sequencer.
// Optional write-back scaling is enabled by defining FFT8_SCALE_EN.
package fft8_pkg;

  typedef enum logic [1:0] {ST_LOAD, ST_COMPUTE, ST_UNLOAD} state_t;

  // Twiddles W^k = exp(-j*2*pi*k/8), {re, im} in Q2.14
  localparam logic [31:0] W0 = 32'h4000_0000;
  localparam logic [31:0] W1 = 32'h2D41_D2BF;
  localparam logic [31:0] W2 = 32'h0000_C000;
  localparam logic [31:0] W3 = 32'hD2BF_D2BF;

  function automatic logic [2:0] bitrev3(input logic [2:0] n);
    return {n[0], n[1], n[2]};
  endfunction

  function automatic logic [2:0] pair_lo(input logic [1:0] stage, input logic [1:0] i);
    case (stage)
      2'd0:    return {i, 1'b0};
      2'd1:    return {i[1], 1'b0, i[0]};
      default: return {1'b0, i};
    endcase
  endfunction

  function automatic logic [2:0] pair_hi(input logic [1:0] stage, input logic [1:0] i);
    case (stage)
      2'd0:    return {i, 1'b1};
      2'd1:    return {i[1], 1'b1, i[0]};
      default: return {1'b1, i};
    endcase
  endfunction

  function automatic logic [1:0] tw_sel(input logic [1:0] stage, input logic [1:0] i);
    case (stage)
      2'd0:    return 2'd0;
      2'd1:    return {i[0], 1'b0};
      default: return i;
    endcase
  endfunction

  function automatic logic [31:0] twiddle(input logic [1:0] sel);
    case (sel)
      2'd0:    return W0;
      2'd1:    return W1;
      2'd2:    return W2;
      default: return W3;
    endcase
  endfunction

  function automatic logic [31:0] wb_scale(input logic [31:0] v);
`ifdef FFT8_SCALE_EN
    return {$signed(v[31:16]) >>> 1, $signed(v[15:0]) >>> 1};
`else
    return v;
`endif
  endfunction

endpackage

// File: rtl/fft8_scheduler_if.sv
// Stream, status and butterfly-side signals of the FFT sequencer.
interface fft8_scheduler_if;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;
  logic        busy;
  logic [31:0] bf_a;
  logic [31:0] bf_b;
  logic [31:0] bf_w;
  logic [31:0] bf_x;
  logic [31:0] bf_y;

  modport master (
    input  s_valid, s_data, m_ready, bf_x, bf_y,
    output s_ready, m_valid, m_data, m_last, busy, bf_a, bf_b, bf_w
  );

  modport slave (
    output s_valid, s_data, m_ready, bf_x, bf_y,
    input  s_ready, m_valid, m_data, m_last, busy, bf_a, bf_b, bf_w
  );
endinterface

// File: rtl/fft8_sample_mem.sv
// 8x32 in-place sample store: two read ports, a paired butterfly write port and a load port.
module fft8_sample_mem (
  input  logic        clk,
  input  logic        ld_en,
  input  logic [2:0]  ld_addr,
  input  logic [31:0] ld_data,
  input  logic [2:0]  ra0,
  input  logic [2:0]  ra1,
  output logic [31:0] rd0,
  output logic [31:0] rd1,
  input  logic        wr_en,
  input  logic [2:0]  wa0,
  input  logic [2:0]  wa1,
  input  logic [31:0] wd0,
  input  logic [31:0] wd1
);
  logic [7:0][31:0] mem;

  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end else if (wr_en) begin
      mem[wa0] <= wd0;
      mem[wa1] <= wd1;
    end
  end

  assign rd0 = mem[ra0];
  assign rd1 = mem[ra1];
endmodule

// File: rtl/fft8_scheduler.sv
// Load / compute / unload sequencer sharing one external pipelined butterfly.
// FFT8_SCALE_EN halves every write-back component (1/8 overall gain).
module fft8_scheduler
  import fft8_pkg::*;
#(
  parameter int BF_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  fft8_scheduler_if.master io
);
  localparam int STAGE_LEN = 4 + BF_LAT;
  localparam int CW        = $clog2(STAGE_LEN);

  state_t                        state, state_nxt;
  logic [2:0]                    cnt;
  logic [1:0]                    stage;
  logic [CW-1:0]                 cyc;
  logic [BF_LAT-1:0]             vld_pipe;
  logic [BF_LAT-1:0][2:0]        lo_pipe, hi_pipe;

  logic        s_fire, m_fire, issue, stage_end;
  logic [1:0]  idx;
  logic [2:0]  lo, hi, ra0;
  logic [31:0] rd0, rd1;

  assign idx       = cyc[1:0];
  assign lo        = pair_lo(stage, idx);
  assign hi        = pair_hi(stage, idx);
  assign stage_end = (cyc == CW'(STAGE_LEN - 1));
  assign issue     = !rst && (state == ST_COMPUTE) && (cyc < CW'(4));

  assign io.s_ready = !rst && (state == ST_LOAD);
  assign io.busy    = !rst && (state == ST_COMPUTE);
  assign io.m_valid = !rst && (state == ST_UNLOAD);
  assign io.m_last  = io.m_valid && (cnt == 3'd7);
  assign io.m_data  = io.m_valid ? rd0 : '0;
  assign io.bf_a    = issue ? rd0 : '0;
  assign io.bf_b    = issue ? rd1 : '0;
  assign io.bf_w    = issue ? twiddle(tw_sel(stage, idx)) : '0;

  assign s_fire = io.s_valid && io.s_ready;
  assign m_fire = io.m_valid && io.m_ready;
  // Port 0 serves butterfly operand a while computing and the output bin while unloading
  assign ra0    = issue ? lo : cnt;

  fft8_sample_mem u_mem (
    .clk     (clk),
    .ld_en   (s_fire),
    .ld_addr (bitrev3(cnt)),
    .ld_data (io.s_data),
    .ra0     (ra0),
    .ra1     (hi),
    .rd0     (rd0),
    .rd1     (rd1),
    .wr_en   (vld_pipe[BF_LAT-1]),
    .wa0     (lo_pipe[BF_LAT-1]),
    .wa1     (hi_pipe[BF_LAT-1]),
    .wd0     (wb_scale(io.bf_x)),
    .wd1     (wb_scale(io.bf_y))
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD:    if (s_fire && cnt == 3'd7) state_nxt = ST_COMPUTE;
      ST_COMPUTE: if (stage == 2'd2 && stage_end) state_nxt = ST_UNLOAD;
      ST_UNLOAD:  if (m_fire && cnt == 3'd7) state_nxt = ST_LOAD;
      default:    state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_LOAD;
      cnt      <= '0;
      stage    <= '0;
      cyc      <= '0;
      vld_pipe <= '0;
    end else begin
      state <= state_nxt;
      if (s_fire || m_fire) cnt <= cnt + 3'd1;
      if (state == ST_COMPUTE) begin
        if (stage_end) begin
          cyc   <= '0;
          stage <= (stage == 2'd2) ? 2'd0 : stage + 2'd1;
        end else begin
          cyc <= cyc + CW'(1);
        end
      end
      vld_pipe[0] <= issue;
      for (int j = 1; j < BF_LAT; j++) vld_pipe[j] <= vld_pipe[j-1];
    end
  end

  // Write-back addresses travel alongside the butterfly latency
  always_ff @(posedge clk) begin
    lo_pipe[0] <= lo;
    hi_pipe[0] <= hi;
    for (int j = 1; j < BF_LAT; j++) begin
      lo_pipe[j] <= lo_pipe[j-1];
      hi_pipe[j] <= hi_pipe[j-1];
    end
  end
endmodule

// File: tb/tb_fft8_scheduler.sv
// Scoreboard bench: two sequencers (BF_LAT 1 and 3) share stimulus; each has a butterfly model.
module tb_fft8_scheduler;
  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid, m_ready;
  logic [31:0] s_data;
  logic [31:0] junk;
  int          cyc = 0;
  int          vecs = 0, errs = 0;
  int          mr_mode = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) junk <= $urandom;

  fft8_scheduler_if if1 ();
  fft8_scheduler_if if3 ();

  fft8_scheduler #(.BF_LAT(1)) u_dut1 (.clk(clk), .rst(rst), .io(if1));
  fft8_scheduler #(.BF_LAT(3)) u_dut3 (.clk(clk), .rst(rst), .io(if3));

  assign if1.s_valid = s_valid;
  assign if1.s_data  = s_data;
  assign if1.m_ready = m_ready;
  assign if3.s_valid = s_valid;
  assign if3.s_data  = s_data;
  assign if3.m_ready = m_ready;

  logic [31:0] wtab [4] = '{32'h4000_0000, 32'h2D41_D2BF, 32'h0000_C000, 32'hD2BF_D2BF};

  // Butterfly x = a + w*b, y = a - w*b with Q2.14 products floored, sums wrapped to 16 bits
  function automatic logic [63:0] bfly(input logic [31:0] a, input logic [31:0] b, input logic [31:0] w);
    int ar, ai, br, bi, wr, wi, pr, pi;
    ar = $signed(a[31:16]); ai = $signed(a[15:0]);
    br = $signed(b[31:16]); bi = $signed(b[15:0]);
    wr = $signed(w[31:16]); wi = $signed(w[15:0]);
    pr = (wr * br - wi * bi) >>> 14;
    pi = (wr * bi + wi * br) >>> 14;
    return {16'(ar + pr), 16'(ai + pi), 16'(ar - pr), 16'(ai - pi)};
  endfunction

  function automatic logic [31:0] sc(input logic [31:0] v);
`ifdef FFT8_SCALE_EN
    return {$signed(v[31:16]) >>> 1, $signed(v[15:0]) >>> 1};
`else
    return v;
`endif
  endfunction

  // External butterfly models; off-slot cycles present random junk that must be ignored
  logic [63:0] p1;
  logic        pv1;
  logic [63:0] p3 [3];
  logic [2:0]  pv3;
  always @(posedge clk) begin
    p1    <= bfly(if1.bf_a, if1.bf_b, if1.bf_w);
    pv1   <= (if1.bf_w != 0);
    p3[0] <= bfly(if3.bf_a, if3.bf_b, if3.bf_w);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
    pv3   <= {pv3[1:0], (if3.bf_w != 0)};
  end
  assign if1.bf_x = pv1    ? p1[63:32]    : junk;
  assign if1.bf_y = pv1    ? p1[31:0]     : ~junk;
  assign if3.bf_x = pv3[2] ? p3[2][63:32] : junk;
  assign if3.bf_y = pv3[2] ? p3[2][31:0]  : ~junk;

  // Reference: textbook iterative radix-2 DIT over a bit-reversed copy
  logic [31:0] frame_x [8];
  logic [31:0] frame_X [8];
  logic [31:0] exp_arr [256];
  int          nexp = 0;

  task automatic fft_ref();
    logic [31:0] v [8];
    logic [63:0] r;
    int half, span;
    for (int n = 0; n < 8; n++) v[((n & 1) << 2) | (n & 2) | (n >> 2)] = frame_x[n];
    for (int s = 0; s < 3; s++) begin
      half = 1 << s;
      span = 2 * half;
      for (int base = 0; base < 8; base += span)
        for (int j = 0; j < half; j++) begin
          r = bfly(v[base + j], v[base + j + half], wtab[j * (8 / span)]);
          v[base + j]        = sc(r[63:32]);
          v[base + j + half] = sc(r[31:0]);
        end
    end
    for (int k = 0; k < 8; k++) frame_X[k] = v[k];
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Monitor state per lane: 0 -> BF_LAT 1, 1 -> BF_LAT 3
  int          rd_ptr [2] = '{0, 0};
  int          acc [2], t8 [2], bcnt [2];
  bit          wf [2], stall [2];
  logic [31:0] held [2];

  task automatic mon(input int ln, input int lat, input logic sv, input logic sr, input logic mv,
                     input logic mr, input logic ml, input logic bz, input logic [31:0] md);
    if (rst) begin
      acc[ln] = 0; wf[ln] = 0; stall[ln] = 0;
      return;
    end
    if (bz) bcnt[ln]++;
    if (sv && sr) begin
      acc[ln]++;
      if (acc[ln] == 8) begin
        acc[ln] = 0; t8[ln] = cyc; wf[ln] = 1; bcnt[ln] = 0;
      end
    end
    if (mv) begin
      chk($sformatf("l%0d s_ready_while_unload", lat), {31'b0, sr}, 32'd0);
      if (wf[ln]) begin
        wf[ln] = 0;
        chk($sformatf("l%0d first_valid_latency", lat), cyc - t8[ln], 1 + 3 * (4 + lat));
        chk($sformatf("l%0d busy_cycles", lat), bcnt[ln], 3 * (4 + lat));
      end
      if (stall[ln]) chk($sformatf("l%0d stall_stable", lat), md, held[ln]);
      chk($sformatf("l%0d m_last", lat), {31'b0, ml}, {31'b0, (rd_ptr[ln] % 8) == 7});
      if (mr) begin
        if (rd_ptr[ln] >= nexp) begin
          vecs++; errs++;
          $display("FAIL l%0d unexpected_output got=%h exp=none", lat, md);
        end else begin
          chk($sformatf("l%0d bin%0d", lat, rd_ptr[ln] % 8), md, exp_arr[rd_ptr[ln]]);
          rd_ptr[ln]++;
        end
      end
    end
    stall[ln] = mv && !mr;
    held[ln]  = md;
  endtask

  always @(negedge clk) begin
    mon(0, 1, if1.s_valid, if1.s_ready, if1.m_valid, if1.m_ready, if1.m_last, if1.busy, if1.m_data);
    mon(1, 3, if3.s_valid, if3.s_ready, if3.m_valid, if3.m_ready, if3.m_last, if3.busy, if3.m_data);
  end

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (mr_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ~m_ready;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic send_frame(input bit junk_after, input bit push);
    int guard = 0;
    while (!(if1.s_ready && if3.s_ready) && guard < 400) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 400) begin
      vecs++; errs++;
      $display("FAIL frame_start_timeout got=busy exp=s_ready");
    end
    for (int n = 0; n < 8; n++) begin
      s_valid = 1'b1;
      s_data  = frame_x[n];
      @(posedge clk); #1;
    end
    // Both lanes are in COMPUTE for these cycles, so this traffic must be ignored
    if (junk_after) repeat (15) begin
      s_data = $urandom;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    if (push) begin
      fft_ref();
      for (int k = 0; k < 8; k++) begin
        exp_arr[nexp] = frame_X[k];
        nexp++;
      end
    end
  endtask

  task automatic rst_checks(input string tag);
    chk({tag, " l1 s_ready"}, {31'b0, if1.s_ready}, 32'd0);
    chk({tag, " l1 m_valid"}, {31'b0, if1.m_valid}, 32'd0);
    chk({tag, " l1 busy"},    {31'b0, if1.busy},    32'd0);
    chk({tag, " l1 bf_a"},    if1.bf_a, 32'd0);
    chk({tag, " l1 bf_w"},    if1.bf_w, 32'd0);
    chk({tag, " l3 s_ready"}, {31'b0, if3.s_ready}, 32'd0);
    chk({tag, " l3 m_last"},  {31'b0, if3.m_last},  32'd0);
    chk({tag, " l3 bf_b"},    if3.bf_b, 32'd0);
  endtask

  initial begin
    int guard;
    rst = 1'b1; s_valid = 1'b0; s_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_checks("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // impulse
    for (int n = 0; n < 8; n++) frame_x[n] = (n == 0) ? 32'h4000_0000 : 32'h0;
    send_frame(1, 1);
    // DC
    for (int n = 0; n < 8; n++) frame_x[n] = 32'h0800_0000;
    send_frame(1, 1);
    // alternating sign, real only
    for (int n = 0; n < 8; n++) frame_x[n] = n[0] ? 32'hF800_0000 : 32'h0800_0000;
    send_frame(1, 1);
    // random frames with toggling and random backpressure
    for (int f = 0; f < 4; f++) begin
      mr_mode = (f == 0) ? 1 : 2;
      for (int n = 0; n < 8; n++) frame_x[n] = $urandom;
      send_frame(f[0], 1);
    end

    // reset mid-COMPUTE: frame discarded
    mr_mode = 0;
    for (int n = 0; n < 8; n++) frame_x[n] = $urandom;
    send_frame(0, 0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst l1 busy",    {31'b0, if1.busy},    32'd0);
    chk("post_rst l1 s_ready", {31'b0, if1.s_ready}, 32'd1);
    chk("post_rst l3 busy",    {31'b0, if3.busy},    32'd0);
    chk("post_rst l3 s_ready", {31'b0, if3.s_ready}, 32'd1);
    repeat (30) @(posedge clk);
    #1;

    // impulse after reset, random backpressure
    mr_mode = 2;
    for (int n = 0; n < 8; n++) frame_x[n] = (n == 0) ? 32'h4000_0000 : 32'h0;
    send_frame(1, 1);

    guard = 0;
    while ((rd_ptr[0] != nexp || rd_ptr[1] != nexp) && guard < 500) begin
      @(posedge clk);
      guard++;
    end
    chk("drain l1 bins", rd_ptr[0], nexp);
    chk("drain l3 bins", rd_ptr[1], nexp);
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
